// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared definitions for the 16-way round-robin arbiter and its mux datapath.
// Optional feature: define ARB_BURST_EN to allow several beats per grant.
package mux16_rr_arbiter_pkg;

    localparam int ARB_NREQ = 16;
    localparam int ARB_IDXW = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // One-hot grant vector for a requester index.
    function automatic logic [15:0] idx_to_onehot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/mux16_rr_arbiter_rr_pick16.sv
// Rotating priority picker: the first set request at or after ptr wins,
// scanning upward and wrapping 15 -> 0.
module rr_pick16
    import mux16_rr_arbiter_pkg::*;
(
    input  logic [15:0] req,
    input  logic [3:0]  ptr,
    output logic        any,
    output logic [3:0]  idx
);

    logic [31:0] dbl_s;
    logic [15:0] rot_s;
    logic [3:0]  off_s;

    // Rotate right by ptr so the current priority holder lands on bit 0.
    assign dbl_s = {req, req} >> ptr;
    assign rot_s = dbl_s[15:0];

    // Priority-encode the rotated vector; the lowest set bit wins.
    always_comb begin
        off_s = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (rot_s[i]) begin
                off_s = 4'(i);
            end else begin
                off_s = off_s;
            end
        end
    end

    assign any = |req;
    assign idx = off_s + ptr;   // 4-bit add undoes the rotation modulo 16

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sharing one 16:1 data mux among 16 requesters.
// A grant is held until the sink takes the beat (out_valid & out_ready),
// then priority moves to the requester after the winner.
// Optional feature: define ARB_BURST_EN to keep a grant for up to MAX_BURST
// back-to-back beats while the winner keeps requesting.
module mux_16 #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]          sel,
    input  logic [16*WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]    out_data
);

    assign out_data = in_data[sel*WIDTH +: WIDTH];

endmodule

module mux16_rr_arbiter
    import mux16_rr_arbiter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [15:0]         req,
    input  logic [16*WIDTH-1:0] in_data,
    output logic [15:0]         ack,
    output logic [15:0]         grant,
    output logic [3:0]          sel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data
);

    arb_state_e  state_r, state_nxt_s;
    logic [15:0] grant_r, grant_nxt_s;
    logic [3:0]  sel_r, sel_nxt_s;
    logic [3:0]  ptr_r, ptr_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic        any_s;
    logic [3:0]  pick_s;
    logic        xfer_s;
    logic        more_s;      // transfer continues the current grant

    rr_pick16 u_pick (
        .req (req),
        .ptr (ptr_r),
        .any (any_s),
        .idx (pick_s)
    );

    mux_16 #(.WIDTH(WIDTH)) u_mux (
        .sel      (sel_r),
        .in_data  (in_data),
        .out_data (out_data)
    );

    assign xfer_s = valid_r & out_ready;

`ifdef ARB_BURST_EN
    logic [3:0] beat_cnt_r, beat_cnt_nxt_s;

    assign more_s = req[sel_r] && (32'(beat_cnt_r) < 32'(MAX_BURST - 1));

    // Beat counter within the current grant.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            beat_cnt_r <= 4'd0;
        end else begin
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end

    // Count beats of a burst; restart at every new grant.
    always_comb begin
        beat_cnt_nxt_s = beat_cnt_r;
        if (state_r == ARB_IDLE) begin
            beat_cnt_nxt_s = 4'd0;
        end else if (xfer_s && more_s) begin
            beat_cnt_nxt_s = beat_cnt_r + 4'd1;
        end else begin
            beat_cnt_nxt_s = beat_cnt_r;
        end
    end
`else
    assign more_s = 1'b0;
`endif

    // State and registered outputs; reset overrides any handshake.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= ARB_IDLE;
            grant_r <= 16'h0000;
            sel_r   <= 4'd0;
            ptr_r   <= 4'd0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            sel_r   <= sel_nxt_s;
            ptr_r   <= ptr_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    // Next state: arbitrate when idle, leave BUSY once the grant is done.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (any_s) begin
                    state_nxt_s = ARB_BUSY;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (xfer_s && !more_s) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_BUSY;
                end
            end
            default: state_nxt_s = ARB_IDLE;
        endcase
    end

    // Next grant/select/pointer/valid; everything holds while the sink stalls.
    always_comb begin
        grant_nxt_s = grant_r;
        sel_nxt_s   = sel_r;
        ptr_nxt_s   = ptr_r;
        valid_nxt_s = valid_r;
        case (state_r)
            ARB_IDLE: begin
                if (any_s) begin
                    grant_nxt_s = idx_to_onehot(pick_s);
                    sel_nxt_s   = pick_s;
                    valid_nxt_s = 1'b1;
                end else begin
                    grant_nxt_s = 16'h0000;
                    valid_nxt_s = 1'b0;
                end
            end
            ARB_BUSY: begin
                if (xfer_s && !more_s) begin
                    grant_nxt_s = 16'h0000;
                    valid_nxt_s = 1'b0;
                    ptr_nxt_s   = sel_r + 4'd1;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            default: begin
                grant_nxt_s = 16'h0000;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    assign ack       = grant_r & {16{xfer_s}};
    assign grant     = grant_r;
    assign sel       = sel_r;
    assign out_valid = valid_r;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Randomized scoreboard bench for mux16_rr_arbiter. A reference model of the
// round-robin rules predicts each granted beat and pushes the winner index;
// a monitor pops it whenever the sink accepts a beat.
module tb_mux16_rr_arbiter;

    localparam int W    = 32;
    localparam int MAXB = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [15:0]     req = 16'h0000;
    logic [16*W-1:0] in_data;
    logic            out_ready = 1'b0;
    logic [15:0]     ack, grant;
    logic [3:0]      sel;
    logic            out_valid;
    logic [W-1:0]    out_data;

    mux16_rr_arbiter #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
        .clock     (clk),
        .reset_n   (rst_n),
        .req       (req),
        .in_data   (in_data),
        .ack       (ack),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Bench-side requester data and reference model state.
    logic [W-1:0] dat [16];
    int  m_busy = 0, m_w = 0, m_ptr = 0, m_cnt = 0;
    int  expq[$];
    int  ack_i = -1;
    bit  keep_i = 1'b0;
    logic [15:0] req_p = 16'h0000;
    bit  rdy_p = 1'b0, rst_p = 1'b0;
    bit  mon_en = 1'b0;
    int  vectors = 0, errors = 0, n_xfer = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply the edge that just passed to the model: inputs seen at it are *_p.
    task automatic model_step();
        bit cont;
        ack_i  = -1;
        keep_i = 1'b0;
        if (!rst_p) begin
            m_busy = 0; m_ptr = 0; m_cnt = 0;
            expq.delete();
        end else if (m_busy != 0) begin
            if (rdy_p) begin
                ack_i = m_w;
                cont  = 1'b0;
`ifdef ARB_BURST_EN
                if (req_p[m_w] && m_cnt < MAXB - 1) begin
                    cont = 1'b1;
                    m_cnt++;
                    expq.push_back(m_w);
                    keep_i = 1'b1;
                end
`endif
                if (!cont) begin
                    m_busy = 0;
                    m_ptr  = (m_w + 1) % 16;
                end
            end
        end else if (req_p != 16'h0000) begin
            for (int k = 0; k < 16; k++) begin
                if (req_p[(m_ptr + k) % 16]) begin
                    m_w = (m_ptr + k) % 16;
                    break;
                end
            end
            m_busy = 1; m_cnt = 0;
            expq.push_back(m_w);
        end
    endtask

    // Choose the inputs for the next edge according to the test phase.
    task automatic drive(input int c);
        logic [15:0] mask;
        int pct;
        bit rdy;
        if (c < 2)                       begin mask = 16'hFFFF; pct = 100; end
        else if (c < 10)                 begin mask = 16'h0010; pct = 100; end
        else if (c < 60)                 begin mask = 16'hFFFF; pct = 100; end
        else if (c < 100)                begin mask = 16'h8001; pct = 100; end
        else if (c < 2000)               begin mask = 16'hFFFF; pct = 30;  end
        else if (c < 2042)               begin mask = 16'hFFFF; pct = 100; end
        else                             begin mask = 16'h0000; pct = 0;   end

        if (c < 2 || (c >= 2000 && c < 2002))             rst_n = 1'b0;
        else if (c >= 100 && c < 2000 && $urandom_range(0, 199) == 0) rst_n = 1'b0;
        else                                              rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if (i == ack_i) begin
                dat[i] = $urandom;
                if (keep_i) req[i] = 1'b1;
                else        req[i] = mask[i] && ($urandom_range(0, 99) < pct);
            end else if (!req[i]) begin
                dat[i] = $urandom;
                req[i] = mask[i] && ($urandom_range(0, 99) < pct);
            end
        end
        if (c >= 100 && c < 2000) rdy = ($urandom_range(0, 99) < 70);
        else                      rdy = 1'b1;
        out_ready = rdy && rst_n;
        for (int i = 0; i < 16; i++) in_data[i*W +: W] = dat[i];
        req_p = req; rdy_p = out_ready; rst_p = rst_n;
    endtask

    // Stimulus and reference model.
    initial begin
        for (int i = 0; i < 16; i++) dat[i] = $urandom;
        for (int i = 0; i < 16; i++) in_data[i*W +: W] = dat[i];
        req = 16'hFFFF;
        for (int c = 0; c < 2162; c++) begin
            @(negedge clk);
            model_step();
            if (c == 2) begin
                chk("reset_grant", 64'(grant), 64'h0);
                chk("reset_sel", 64'(sel), 64'h0);
                chk("reset_valid", 64'(out_valid), 64'h0);
                req = 16'h0000;
                mon_en = 1'b1;
            end
            drive(c);
        end
        @(negedge clk);
        #3;
        chk("queue_drained", 64'(expq.size()), 64'h0);
        chk("transfers_seen", 64'(n_xfer > 100), 64'h1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Monitor: compare outputs to the model and pop on each accepted beat.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("out_valid", 64'(out_valid), 64'(m_busy != 0));
                if (m_busy != 0) begin
                    chk("grant", 64'(grant), 64'(16'h0001 << m_w));
                    chk("sel", 64'(sel), 64'(m_w));
                    chk("ack", 64'(ack), out_ready ? 64'(16'h0001 << m_w) : 64'h0);
                end else begin
                    chk("grant_idle", 64'(grant), 64'h0);
                    chk("ack_idle", 64'(ack), 64'h0);
                end
                if (out_valid && out_ready) begin
                    n_xfer++;
                    if (expq.size() == 0) begin
                        chk("unexpected_beat", 64'(sel), 64'hFFFF);
                    end else begin
                        e = expq.pop_front();
                        chk("beat_sel", 64'(sel), 64'(e));
                        chk("beat_data", 64'(out_data), 64'(dat[e]));
                    end
                end
            end
        end
    end

endmodule
